// File: rtl/hex_display_pkg.sv
// Shared constants for the seven-segment display controller: glyphs, blank pattern,
// segment bit positions and an output-polarity helper.
package hex_display_pkg;

    // Bit positions inside a {g,f,e,d,c,b,a} segment field.
    typedef enum int {
        SEG_A = 0,
        SEG_B = 1,
        SEG_C = 2,
        SEG_D = 3,
        SEG_E = 4,
        SEG_F = 5,
        SEG_G = 6
    } seg_bit_e;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

    // Internal "lit" is 1; boards with sinking drivers want the complement.
    function automatic logic [6:0] seg_polarity(input logic [6:0] lit, input logic active_low);
        return active_low ? ~lit : lit;
    endfunction

endpackage

// File: rtl/hex_display_ctrl_if.sv
// Bundle of the display controller's data inputs and display outputs.
// load is a plain capture strobe: every cycle it is high, hex_in/dp_in/blink_in are taken;
// there is no ready/backpressure, the controller always accepts.
interface hex_display_ctrl_if #(
    parameter int NUM_DIGITS = 6
);
    logic [4*NUM_DIGITS-1:0] hex_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blink_in;
    logic                    load;
    logic                    blank_lz;
    logic [7*NUM_DIGITS-1:0] seg_out;
    logic [NUM_DIGITS-1:0]   dp_out;
    logic [6:0]              scan_seg;
    logic                    scan_dp;
    logic [NUM_DIGITS-1:0]   scan_an;

    modport master (
        output hex_in, dp_in, blink_in, load, blank_lz,
        input  seg_out, dp_out, scan_seg, scan_dp, scan_an
    );

    modport slave (
        input  hex_in, dp_in, blink_in, load, blank_lz,
        output seg_out, dp_out, scan_seg, scan_dp, scan_an
    );
endinterface

// File: rtl/hex_seg_decode.sv
// Combinational nibble to seven-segment glyph lookup (lit = 1, lowercase b and d).
module hex_seg_decode
    import hex_display_pkg::*;
(
    input  logic [3:0]         nib_i,
    output logic [SEG_G:SEG_A] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (nib_i)
            4'h0: seg_o = GLYPH_0;
            4'h1: seg_o = GLYPH_1;
            4'h2: seg_o = GLYPH_2;
            4'h3: seg_o = GLYPH_3;
            4'h4: seg_o = GLYPH_4;
            4'h5: seg_o = GLYPH_5;
            4'h6: seg_o = GLYPH_6;
            4'h7: seg_o = GLYPH_7;
            4'h8: seg_o = GLYPH_8;
            4'h9: seg_o = GLYPH_9;
            4'hA: seg_o = GLYPH_A;
            4'hB: seg_o = GLYPH_B;
            4'hC: seg_o = GLYPH_C;
            4'hD: seg_o = GLYPH_D;
            4'hE: seg_o = GLYPH_E;
            4'hF: seg_o = GLYPH_F;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// Multi-digit seven-segment controller: shadow capture, decode, leading-zero blanking,
// per-digit blink and a time-multiplexed scan port, all outputs registered.
module hex_display_ctrl
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS     = 6,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter int BLINK_DIV      = 25_000_000,
    parameter int SCAN_DIV       = 50_000
) (
    input logic               clk,
    input logic               rst,
    hex_display_ctrl_if.slave bus
);

    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam int SW = $clog2(SCAN_DIV + 1);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [NUM_DIGITS-1:0] DIG_POL = {NUM_DIGITS{SEG_ACTIVE_LOW}};

    logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   blink_q, blink_d;
    logic [BW-1:0]           blink_cnt_q, blink_cnt_d;
    logic                    phase_q, phase_d;
    logic [SW-1:0]           scan_cnt_q, scan_cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [7*NUM_DIGITS-1:0] seg_out_q, seg_out_d;
    logic [NUM_DIGITS-1:0]   dp_out_q, dp_out_d;
    logic [6:0]              scan_seg_q, scan_seg_d;
    logic                    scan_dp_q, scan_dp_d;
    logic [NUM_DIGITS-1:0]   scan_an_q, scan_an_d;

    logic [3:0]            nib     [NUM_DIGITS];
    logic [6:0]            glyph   [NUM_DIGITS];
    logic [6:0]            lit_seg [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] lit_dp;
    logic                  lz_run, lz_blank, blink_off;
    logic                  blink_wrap, scan_wrap;

    // Array index g is the display position: 0 is the most significant digit.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        assign nib[g] = hex_q[4*(NUM_DIGITS-1-g) +: 4];
        hex_seg_decode u_dec (
            .nib_i (nib[g]),
            .seg_o (glyph[g])
        );
    end

    always_comb begin
        hex_d   = bus.load ? bus.hex_in   : hex_q;
        dp_d    = bus.load ? bus.dp_in    : dp_q;
        blink_d = bus.load ? bus.blink_in : blink_q;
    end

    // lz_run stays high only while every digit seen so far is zero.
    always_comb begin
        lz_run    = 1'b1;
        lz_blank  = 1'b0;
        blink_off = 1'b0;
        lit_dp    = '0;
        seg_out_d = '0;
        dp_out_d  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            lit_seg[i] = SEG_BLANK;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            lz_run     = lz_run && (nib[i] == 4'h0);
            lz_blank   = bus.blank_lz && lz_run && (i != NUM_DIGITS - 1);
            blink_off  = phase_q && blink_q[NUM_DIGITS-1-i];
            lit_seg[i] = (blink_off || lz_blank) ? SEG_BLANK : glyph[i];
            lit_dp[i]  = !blink_off && dp_q[NUM_DIGITS-1-i];
            seg_out_d[7*(NUM_DIGITS-1-i) +: 7] = seg_polarity(lit_seg[i], SEG_ACTIVE_LOW);
            dp_out_d[NUM_DIGITS-1-i]           = lit_dp[i] ^ SEG_ACTIVE_LOW;
        end
    end

    // Scan registers are loaded from the next index so anode and segments move together.
    always_comb begin
        blink_wrap  = (blink_cnt_q == BW'(BLINK_DIV - 1));
        blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + 1'b1;
        phase_d     = phase_q ^ blink_wrap;
        scan_wrap   = (scan_cnt_q == SW'(SCAN_DIV - 1));
        scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + 1'b1;
        idx_d       = idx_q;
        if (scan_wrap) begin
            idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        scan_seg_d = seg_polarity(lit_seg[idx_d], SEG_ACTIVE_LOW);
        scan_dp_d  = lit_dp[idx_d] ^ SEG_ACTIVE_LOW;
        scan_an_d  = (NUM_DIGITS'(1) << idx_d) ^ DIG_POL;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hex_q       <= '0;
            dp_q        <= '0;
            blink_q     <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            scan_cnt_q  <= '0;
            idx_q       <= '0;
            seg_out_q   <= {NUM_DIGITS{seg_polarity(GLYPH_0, SEG_ACTIVE_LOW)}};
            dp_out_q    <= DIG_POL;
            scan_seg_q  <= seg_polarity(GLYPH_0, SEG_ACTIVE_LOW);
            scan_dp_q   <= SEG_ACTIVE_LOW;
            scan_an_q   <= NUM_DIGITS'(1) ^ DIG_POL;
        end else begin
            hex_q       <= hex_d;
            dp_q        <= dp_d;
            blink_q     <= blink_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            seg_out_q   <= seg_out_d;
            dp_out_q    <= dp_out_d;
            scan_seg_q  <= scan_seg_d;
            scan_dp_q   <= scan_dp_d;
            scan_an_q   <= scan_an_d;
        end
    end

    assign bus.seg_out  = seg_out_q;
    assign bus.dp_out   = dp_out_q;
    assign bus.scan_seg = scan_seg_q;
    assign bus.scan_dp  = scan_dp_q;
    assign bus.scan_an  = scan_an_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Bench for hex_display_ctrl: directed display cases, randomized traffic and a mid-run
// reset, all compared against a cycle-count reference model of the display.
module tb_hex_display_ctrl;

    localparam int N  = 6;
    localparam int BD = 4;
    localparam int SD = 3;
    localparam int EW = 7*N + N + 7 + 1 + N;
    localparam int O_AN   = 0;
    localparam int O_SDP  = N;
    localparam int O_SSEG = N + 1;
    localparam int O_DP   = N + 8;
    localparam int O_SEG  = 2*N + 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    hex_display_ctrl_if #(.NUM_DIGITS(N)) bus ();

    hex_display_ctrl #(
        .NUM_DIGITS     (N),
        .SEG_ACTIVE_LOW (1'b1),
        .BLINK_DIV      (BD),
        .SCAN_DIV       (SD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic [4*N-1:0] m_hex;
    logic [N-1:0]   m_dp;
    logic [N-1:0]   m_blink;
    int             t;
    logic [EW-1:0]  exp_q [$];
    int             checks = 0;
    int             errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (t=%0d)", tag, got, exp, t);
        end
    endtask

    // Outputs after the next edge, given t edges since reset and the model's current shadows.
    function automatic logic [EW-1:0] model_out(input int tp, input logic blz);
        logic [7*N-1:0] seg;
        logic [N-1:0]   dp;
        logic [N-1:0]   an;
        logic [6:0]     sseg;
        logic           sdp;
        logic [6:0]     lit;
        logic           ldp, off, lz, phase;
        logic [3:0]     nib;
        int             idx;
        phase = ((tp / BD) % 2) == 1;
        idx   = ((tp + 1) / SD) % N;
        seg   = '0;
        dp    = '0;
        sseg  = '0;
        sdp   = 1'b0;
        for (int i = 0; i < N; i++) begin
            nib = m_hex[4*(N-1-i) +: 4];
            off = phase && m_blink[N-1-i];
            lz  = blz && (i < N - 1) && (longint'(m_hex) < (longint'(1) << (4*(N-1-i))));
            lit = (off || lz) ? 7'h00 : glyph_tab[nib];
            ldp = !off && m_dp[N-1-i];
            seg[7*(N-1-i) +: 7] = ~lit;
            dp[N-1-i]           = ~ldp;
            if (i == idx) begin
                sseg = ~lit;
                sdp  = ~ldp;
            end
        end
        an = ~(N'(1) << idx);
        return {seg, dp, sseg, sdp, an};
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_seg"},   64'(bus.seg_out),  64'({6{7'b1000000}}));
        check({tag, "_dp"},    64'(bus.dp_out),   64'(6'h3F));
        check({tag, "_sseg"},  64'(bus.scan_seg), 64'(7'b1000000));
        check({tag, "_sdp"},   64'(bus.scan_dp),  64'(1'b1));
        check({tag, "_san"},   64'(bus.scan_an),  64'(6'b111110));
    endtask

    // Called at a falling edge; drives inputs, predicts, clocks once, compares.
    task automatic cycle(input logic [4*N-1:0] h, input logic [N-1:0] d, input logic [N-1:0] b,
                         input logic ld, input logic blz);
        logic [EW-1:0] e;
        logic [EW-1:0] got;
        bus.hex_in   = h;
        bus.dp_in    = d;
        bus.blink_in = b;
        bus.load     = ld;
        bus.blank_lz = blz;
        exp_q.push_back(model_out(t, blz));
        if (ld) begin
            m_hex   = h;
            m_dp    = d;
            m_blink = b;
        end
        @(posedge clk);
        t++;
        #1;
        got = {bus.seg_out, bus.dp_out, bus.scan_seg, bus.scan_dp, bus.scan_an};
        e   = exp_q.pop_front();
        check("seg_out",  64'(got[O_SEG +: 7*N]),  64'(e[O_SEG +: 7*N]));
        check("dp_out",   64'(got[O_DP +: N]),     64'(e[O_DP +: N]));
        check("scan_seg", 64'(got[O_SSEG +: 7]),   64'(e[O_SSEG +: 7]));
        check("scan_dp",  64'(got[O_SDP]),         64'(e[O_SDP]));
        check("scan_an",  64'(got[O_AN +: N]),     64'(e[O_AN +: N]));
        @(negedge clk);
    endtask

    task automatic release_reset();
        bus.load = 1'b0;
        rst      = 1'b1;
        t        = 0;
        m_hex    = '0;
        m_dp     = '0;
        m_blink  = '0;
        exp_q.delete();
    endtask

    logic [4*N-1:0] rh;
    logic           rblz;

    initial begin
        bus.hex_in   = 24'hABCDEF;
        bus.dp_in    = '1;
        bus.blink_in = '1;
        bus.load     = 1'b1;
        bus.blank_lz = 1'b1;
        t            = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        release_reset();

        // Capture then display; the first cycle also confirms load under reset was dropped.
        cycle(24'h12AB0F, 6'b000100, 6'b000000, 1'b1, 1'b0);
        cycle(24'h12AB0F, 6'b000100, 6'b000000, 1'b0, 1'b0);
        check("glyphs_12AB0F", 64'(bus.seg_out),
              64'({~7'h06, ~7'h5B, ~7'h77, ~7'h7C, ~7'h3F, ~7'h71}));
        check("dp_digit3", 64'(bus.dp_out), 64'(6'b111011));

        cycle(24'h000400, 6'b000000, 6'b000000, 1'b1, 1'b1);
        cycle(24'h000400, 6'b000000, 6'b000000, 1'b0, 1'b1);
        check("lz_000400", 64'(bus.seg_out),
              64'({7'h7F, 7'h7F, 7'h7F, ~7'h66, ~7'h3F, ~7'h3F}));
        cycle(24'h000000, 6'b000000, 6'b000000, 1'b1, 1'b1);
        cycle(24'h000000, 6'b000000, 6'b000000, 1'b0, 1'b1);
        check("lz_zero", 64'(bus.seg_out), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, ~7'h3F}));
        cycle(24'h000000, 6'b000000, 6'b000000, 1'b0, 1'b0);
        check("lz_off", 64'(bus.seg_out), 64'({6{~7'h3F}}));

        // Blink on the last digit, long enough for several phase flips and scan wraps.
        cycle(24'h12AB0F, 6'b000011, 6'b000001, 1'b1, 1'b0);
        for (int k = 0; k < 24; k++) cycle(24'h12AB0F, 6'b000011, 6'b000001, 1'b0, 1'b0);

        rblz = 1'b0;
        for (int k = 0; k < 300; k++) begin
            rh = 24'($urandom);
            if ($urandom_range(0, 2) != 0) rh = rh >> (4 * $urandom_range(0, 6));
            if ($urandom_range(0, 7) == 0) rblz = ~rblz;
            cycle(rh, N'($urandom), N'($urandom), ($urandom_range(0, 3) == 0), rblz);
        end

        // Arrange blink phase 1 with blinking digits, then reset between edges.
        cycle(24'h876543, 6'b101010, 6'b111111, 1'b1, 1'b0);
        for (int k = 0; k < 2*BD && ((t / BD) % 2) == 0; k++)
            cycle(24'h876543, 6'b101010, 6'b111111, 1'b0, 1'b0);
        check("phase_before_reset", 64'(((t / BD) % 2)), 64'(1));
        #2 rst = 1'b0;
        #1 check_reset_state("async_reset");
        bus.hex_in = 24'h9F9F9F;
        bus.dp_in  = '1;
        bus.load   = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_reset_state("load_in_reset");
        @(negedge clk);
        release_reset();
        cycle(24'h9F9F9F, 6'b111111, 6'b000000, 1'b0, 1'b0);
        for (int k = 0; k < 30; k++)
            cycle(24'($urandom), N'($urandom), N'($urandom), ($urandom_range(0, 2) == 0), 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
